keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
Input-side counterpart of the ASCII dot-matrix display path. It scans a 4x4 membrane keypad by driving rows and reading columns, then debounces the result. Each accepted keypress is emitted as a 7-bit ASCII code with a one-cycle valid strobe. It sits between the keypad pins and game/display logic, which consumes ASCII directly.

Parameters:
ROWS, 4, keypad rows driven (fixed 4 for the key map)
COLS, 4, keypad columns sensed (fixed 4 for the key map)
SCAN_DIV, 1000, clk cycles each row is driven (dwell); must be >= 3
DEBOUNCE_SCANS, 4, consecutive identical full-frame results required to accept a press or a release

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
col_in  input  COLS  column sense, active-low (external pull-ups); asynchronous to clk
row_out  output  ROWS  row drive, active-low one-hot
ascii_code  output  7  ASCII code of the most recently accepted key
key_valid  output  1  one-cycle pulse when ascii_code updates
key_held  output  1  level, high from acceptance until release is accepted

Behaviour:
- Reset (async, rst_n=0): row_out=4'b1110, ascii_code=7'h00, key_valid=0, key_held=0; all counters and the state machine at 0/IDLE. Reset mid-debounce or mid-hold discards the key; no pulse is emitted.
- col_in passes through a 2-flop synchronizer before any use.
- Dwell counter counts 0..SCAN_DIV-1 per row. Synchronized columns are sampled at count SCAN_DIV-1, which allows settling plus synchronizer latency. Then row_out rotates (row r -> r+1, wrapping 3 -> 0).
- Frame = 4 dwells = 4*SCAN_DIV cycles. During a frame, the first pressed key by priority (lowest row, then lowest col) is captured as a 4-bit index {row,col} plus a found flag. Multiple/ghost keys: only the priority winner is reported.
- At frame end, the frame result feeds the FSM:
  - IDLE: found -> DEBOUNCE, cand=index, cnt=1.
  - DEBOUNCE: found and index==cand -> cnt++. If not found, return to IDLE. If a different index is found, stay in DEBOUNCE with cand=new, cnt=1. When cnt reaches DEBOUNCE_SCANS: go to PRESSED, set ascii_code=map(cand), key_valid=1 for exactly that cycle, key_held=1.
  - PRESSED: a frame where cand is absent -> RELEASE with rcnt=1. Other keys appearing while cand is held are ignored.
  - RELEASE: cand absent -> rcnt++. If cand reappears, return to PRESSED. When rcnt reaches DEBOUNCE_SCANS: key_held=0, go to IDLE.
- Latency: press stable from frame k -> key_valid at the end of frame k+DEBOUNCE_SCANS-1.
- ascii_code holds its value after release until the next acceptance.
- Key map, row-major:
  - row 0: '1','2','3','A' = 31,32,33,41
  - row 1: '4','5','6','B' = 34,35,36,42
  - row 2: '7','8','9','C' = 37,38,39,43
  - row 3: '*','0','#','D' = 2A,30,23,44
- Counter widths: $clog2(SCAN_DIV) for dwell, $clog2(DEBOUNCE_SCANS+1) for debounce; no overflow is possible.

Optional Feature:
KEYPAD_TYPEMATIC_EN:
- Defined: while in PRESSED, an auto-repeat frame counter runs. It re-pulses key_valid (same ascii_code) after REPEAT_DELAY_FRAMES=32 frames, then every REPEAT_RATE_FRAMES=8 frames. The counter clears on entering RELEASE. A return to PRESSED from RELEASE does not restart the initial delay.
- Undefined: exactly one key_valid pulse per press.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE)
  - 16-entry key-index -> ASCII map function
  - REPEAT_DELAY_FRAMES and REPEAT_RATE_FRAMES
- Sub-module keypad_debounce: the FSM and counters, consuming {found, index, frame_end} and producing key_valid, key_held and the accepted index. The scanner top owns the synchronizer, dwell counter, row rotation and priority capture.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2 (frame = 16 cycles).
1. Assert rst_n=0 with random col_in -> row_out=1110, key_valid=0, key_held=0, ascii_code=00. Release -> row_out rotates 1110,1101,1011,0111 every 4 cycles.
2. Hold row 1/col 2 ('6') for 4 frames -> exactly one key_valid pulse with ascii_code=7'h36, 2 frames after stable onset. key_held=1 until 2 frames after release.
3. Bounce '0' (row 3/col 1) present/absent on alternating frames -> no key_valid. Then hold it stable -> single pulse, ascii_code=7'h30.
4. Press '1' and 'D' simultaneously -> ascii_code=7'h31 only. Release '1' while 'D' is still held -> key_held drops after 2 frames, then 'D' is accepted as 7'h44.
5. Pull rst_n low mid-DEBOUNCE of '#' -> no pulse; after reset, a fresh 2-frame debounce yields 7'h23.
6. With KEYPAD_TYPEMATIC_EN defined, hold 'A' 60 frames -> pulses at acceptance, +32 frames, then every 8 frames (5 total), all with 7'h41. Without the macro -> 1 pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: debounce FSM states,
// typematic repeat timing and the key-index to ASCII map.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam int REPEAT_DELAY_FRAMES = 32;
    localparam int REPEAT_RATE_FRAMES  = 8;

    // Index is {row[1:0], col[1:0]}, row-major from the top-left key.
    function automatic logic [6:0] key_map(input logic [3:0] idx);
        logic [6:0] code;
        case (idx)
            4'd0:    code = 7'h31;
            4'd1:    code = 7'h32;
            4'd2:    code = 7'h33;
            4'd3:    code = 7'h41;
            4'd4:    code = 7'h34;
            4'd5:    code = 7'h35;
            4'd6:    code = 7'h36;
            4'd7:    code = 7'h42;
            4'd8:    code = 7'h37;
            4'd9:    code = 7'h38;
            4'd10:   code = 7'h39;
            4'd11:   code = 7'h43;
            4'd12:   code = 7'h2A;
            4'd13:   code = 7'h30;
            4'd14:   code = 7'h23;
            4'd15:   code = 7'h44;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate press/release debounce FSM for the keypad scanner.
// KEYPAD_TYPEMATIC_EN adds auto-repeat of key_valid while a key stays held.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_end,
    input  logic        found,
    input  logic [3:0]  index,
    input  logic [15:0] frame_keys,
    output logic        key_valid,
    output logic        key_held,
    output logic [3:0]  key_index
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DS_C  = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    kp_state_e     state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc_s;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic          cand_present_s;

`ifdef KEYPAD_TYPEMATIC_EN
    logic [5:0]    rep_q, rep_d;
    logic [5:0]    rep_inc_s;
    logic          rep_first_q, rep_first_d;
`endif

    assign cand_present_s = frame_keys[cand_q];
    assign cnt_inc_s      = cnt_q + ONE_C;

    // Next-state logic; everything advances only on a completed frame.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_TYPEMATIC_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        rep_inc_s   = rep_q + 6'd1;
`endif
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        cand_d = index;
                        if (ONE_C == DS_C) begin
                            state_d     = ST_PRESSED;
                            cnt_d       = '0;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
                            rep_d       = 6'd0;
                            rep_first_d = 1'b0;
`endif
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = ONE_C;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!found) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (index != cand_q) begin
                        cand_d = index;
                        cnt_d  = ONE_C;
                    end else if (cnt_inc_s == DS_C) begin
                        state_d     = ST_PRESSED;
                        cnt_d       = '0;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
                        rep_d       = 6'd0;
                        rep_first_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_PRESSED: begin
                    if (!cand_present_s) begin
`ifdef KEYPAD_TYPEMATIC_EN
                        rep_d = 6'd0;
`endif
                        if (ONE_C == DS_C) begin
                            state_d    = ST_IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = ONE_C;
                        end
                    end else begin
`ifdef KEYPAD_TYPEMATIC_EN
                        // First repeat waits the long delay, later ones the short rate.
                        if (!rep_first_q && rep_inc_s == 6'(REPEAT_DELAY_FRAMES)) begin
                            key_valid_d = 1'b1;
                            rep_d       = 6'd0;
                            rep_first_d = 1'b1;
                        end else if (rep_first_q && rep_inc_s == 6'(REPEAT_RATE_FRAMES)) begin
                            key_valid_d = 1'b1;
                            rep_d       = 6'd0;
                        end else begin
                            rep_d = rep_inc_s;
                        end
`else
                        cnt_d = '0;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (cand_present_s) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc_s == DS_C) begin
                        state_d    = ST_IDLE;
                        cnt_d      = '0;
                        key_held_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_q       <= 6'd0;
            rep_first_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign key_index = cand_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: column synchronizer, row dwell/rotation and per-frame
// priority capture feeding keypad_debounce (auto-repeat under KEYPAD_TYPEMATIC_EN).
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic [6:0]      ascii_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    col_meta_q, col_sync_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_out_q, row_out_d;
    logic          found_q, found_d;
    logic [3:0]    idx_q, idx_d;
    logic [15:0]   keys_q, keys_d;
    logic          frame_end_q, frame_end_d;
    logic          frame_found_q, frame_found_d;
    logic [3:0]    frame_idx_q, frame_idx_d;
    logic [15:0]   frame_keys_q, frame_keys_d;
    logic [6:0]    ascii_q, ascii_d;
    logic          key_valid_q, key_held_q;

    logic [3:0]    pressed_s;
    logic          hit_s;
    logic [1:0]    hit_col_s;
    logic [15:0]   row_keys_s;
    logic          db_valid_s, db_held_s;
    logic [3:0]    db_index_s;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    assign pressed_s  = ~col_sync_q;
    assign hit_s      = |pressed_s;
    assign hit_col_s  = pressed_s[0] ? 2'd0 : pressed_s[1] ? 2'd1 : pressed_s[2] ? 2'd2 : 2'd3;
    assign row_keys_s = {12'd0, pressed_s} << {row_idx_q, 2'b00};

    // Dwell timing, row rotation and frame capture; columns are read on the last dwell cycle.
    always_comb begin
        dwell_d       = dwell_q + DW'(1);
        row_idx_d     = row_idx_q;
        row_out_d     = row_out_q;
        found_d       = found_q;
        idx_d         = idx_q;
        keys_d        = keys_q;
        frame_end_d   = 1'b0;
        frame_found_d = frame_found_q;
        frame_idx_d   = frame_idx_q;
        frame_keys_d  = frame_keys_q;
        if (dwell_q == DWELL_LAST) begin
            dwell_d   = '0;
            row_idx_d = row_idx_q + 2'd1;
            row_out_d = {row_out_q[2:0], row_out_q[3]};
            keys_d    = keys_q | row_keys_s;
            if (!found_q && hit_s) begin
                found_d = 1'b1;
                idx_d   = {row_idx_q, hit_col_s};
            end else begin
                found_d = found_q;
            end
            if (row_idx_q == 2'd3) begin
                frame_end_d   = 1'b1;
                frame_found_d = found_d;
                frame_idx_d   = idx_d;
                frame_keys_d  = keys_d;
                found_d       = 1'b0;
                idx_d         = 4'd0;
                keys_d        = 16'd0;
            end else begin
                frame_end_d = 1'b0;
            end
        end else begin
            row_idx_d = row_idx_q;
        end
    end

    // Scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q       <= '0;
            row_idx_q     <= 2'd0;
            row_out_q     <= 4'b1110;
            found_q       <= 1'b0;
            idx_q         <= 4'd0;
            keys_q        <= 16'd0;
            frame_end_q   <= 1'b0;
            frame_found_q <= 1'b0;
            frame_idx_q   <= 4'd0;
            frame_keys_q  <= 16'd0;
        end else begin
            dwell_q       <= dwell_d;
            row_idx_q     <= row_idx_d;
            row_out_q     <= row_out_d;
            found_q       <= found_d;
            idx_q         <= idx_d;
            keys_q        <= keys_d;
            frame_end_q   <= frame_end_d;
            frame_found_q <= frame_found_d;
            frame_idx_q   <= frame_idx_d;
            frame_keys_q  <= frame_keys_d;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_end  (frame_end_q),
        .found      (frame_found_q),
        .index      (frame_idx_q),
        .frame_keys (frame_keys_q),
        .key_valid  (db_valid_s),
        .key_held   (db_held_s),
        .key_index  (db_index_s)
    );

    // ascii_code only changes alongside a key_valid pulse and otherwise holds.
    always_comb begin
        if (db_valid_s) begin
            ascii_d = key_map(db_index_s);
        end else begin
            ascii_d = ascii_q;
        end
    end

    // Output registers, kept aligned with each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ascii_q     <= 7'h00;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            ascii_q     <= ascii_d;
            key_valid_q <= db_valid_s;
            key_held_q  <= db_held_s;
        end
    end

    assign row_out    = row_out_q;
    assign ascii_code = ascii_q;
    assign key_valid  = key_valid_q;
    assign key_held   = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle frames).
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [6:0]  ascii_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys = 16'd0;
    logic        force_col = 1'b1;
    logic [3:0]  rand_col = 4'hF;

    int          n_tests = 0;
    int          n_fail = 0;
    int          pulse_cnt = 0;
    int          fall_cnt = 0;
    logic [6:0]  last_code = 7'h00;
    logic        held_prev = 1'b0;
    int          p0;
    int          f0;
    int          exp_rep;

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_in     (col_in),
        .row_out    (row_out),
        .ascii_code (ascii_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: a column reads low when a pressed key sits on a driven (low) row.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
        if (force_col) col_in = rand_col;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulse_cnt <= pulse_cnt + 1;
            last_code <= ascii_code;
        end
        held_prev <= key_held;
        if (held_prev && !key_held) fall_cnt <= fall_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset values with random columns, then row rotation.
        for (int i = 0; i < 6; i++) begin
            rand_col = 4'($urandom);
            @(negedge clk);
        end
        check("rst_row_out", 16'(row_out), 16'h000E);
        check("rst_key_valid", 16'(key_valid), 16'h0000);
        check("rst_key_held", 16'(key_held), 16'h0000);
        check("rst_ascii", 16'(ascii_code), 16'h0000);
        force_col = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        check("rot_row0", 16'(row_out), 16'h000E);
        cyc(1);
        check("rot_row1", 16'(row_out), 16'h000D);
        cyc(4);
        check("rot_row2", 16'(row_out), 16'h000B);
        cyc(4);
        check("rot_row3", 16'(row_out), 16'h0007);
        cyc(4);
        check("rot_wrap", 16'(row_out), 16'h000E);

        // 2: hold '6', single pulse, release debounce.
        p0 = pulse_cnt;
        keys[6] = 1'b1;
        cyc(14);
        check("six_not_early", 16'(pulse_cnt - p0), 16'd0);
        cyc(26);
        check("six_pulse", 16'(pulse_cnt - p0), 16'd1);
        check("six_code", 16'(last_code), 16'h0036);
        check("six_held", 16'(key_held), 16'd1);
        cyc(24);
        check("six_single", 16'(pulse_cnt - p0), 16'd1);
        keys[6] = 1'b0;
        cyc(8);
        check("six_held_after_rel", 16'(key_held), 16'd1);
        cyc(48);
        check("six_released", 16'(key_held), 16'd0);
        check("six_no_rel_pulse", 16'(pulse_cnt - p0), 16'd1);
        check("six_code_kept", 16'(ascii_code), 16'h0036);

        // 3: bouncing '0' never accepted, then stable.
        p0 = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            keys[13] = ~keys[13];
            cyc(16);
        end
        check("bounce_no_pulse", 16'(pulse_cnt - p0), 16'd0);
        check("bounce_no_held", 16'(key_held), 16'd0);
        keys[13] = 1'b1;
        cyc(64);
        check("zero_pulse", 16'(pulse_cnt - p0), 16'd1);
        check("zero_code", 16'(last_code), 16'h0030);
        keys[13] = 1'b0;
        cyc(64);
        check("zero_released", 16'(key_held), 16'd0);

        // 4: '1' and 'D' together, then release '1' only.
        p0 = pulse_cnt;
        f0 = fall_cnt;
        keys[0] = 1'b1;
        keys[15] = 1'b1;
        cyc(64);
        check("multi_pulse", 16'(pulse_cnt - p0), 16'd1);
        check("multi_code", 16'(last_code), 16'h0031);
        keys[0] = 1'b0;
        cyc(112);
        check("d_fall", 16'(fall_cnt - f0), 16'd1);
        check("d_pulses", 16'(pulse_cnt - p0), 16'd2);
        check("d_code", 16'(last_code), 16'h0044);
        check("d_held", 16'(key_held), 16'd1);
        keys[15] = 1'b0;
        cyc(64);

        // 5: reset in the middle of debouncing '#'.
        p0 = pulse_cnt;
        keys[14] = 1'b1;
        cyc(16);
        check("hash_pre_rst", 16'(pulse_cnt - p0), 16'd0);
        rst_n = 1'b0;
        cyc(3);
        check("hash_rst_valid", 16'(key_valid), 16'd0);
        check("hash_rst_held", 16'(key_held), 16'd0);
        check("hash_rst_ascii", 16'(ascii_code), 16'h0000);
        check("hash_rst_row", 16'(row_out), 16'h000E);
        check("hash_rst_no_pulse", 16'(pulse_cnt - p0), 16'd0);
        rst_n = 1'b1;
        cyc(64);
        check("hash_pulse", 16'(pulse_cnt - p0), 16'd1);
        check("hash_code", 16'(last_code), 16'h0023);
        keys[14] = 1'b0;
        cyc(64);

        // 6: long hold of 'A' (auto-repeat only with the typematic build).
`ifdef KEYPAD_TYPEMATIC_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        p0 = pulse_cnt;
        keys[3] = 1'b1;
        cyc(960);
        check("a_pulses", 16'(pulse_cnt - p0), 16'(exp_rep));
        check("a_code", 16'(last_code), 16'h0041);
        check("a_held", 16'(key_held), 16'd1);
        keys[3] = 1'b0;
        cyc(64);
        check("a_released", 16'(key_held), 16'd0);
        check("a_no_extra", 16'(pulse_cnt - p0), 16'(exp_rep));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
